// File: rtl/store_merge_unit.sv
// store_merge_unit
// Performs word, halfword and byte stores on a memory that only accepts
// full-word writes. Word stores are written straight through. Sub-word stores
// read the target word, replace the addressed byte lanes, and write the merged
// word back. The control FSM starts a store with `start` and waits for `done`.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   start       store request, sampled only in IDLE
//   size        00 word, 01 halfword, 10 byte, 11 reserved (error)
//   addr_lo     byte offset within the word (little-endian lanes)
//   reg_B_data  store source; low 8/16 bits are used for sub-word stores
//   mem_rdata   memory read data, valid RD_LAT cycles after mem_rd
//   mem_rd      one-cycle memory read strobe
//   mem_wr      one-cycle memory write strobe
//   mem_wdata   registered write data, stable through the mem_wr cycle
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//   misaligned  error flag of the last accepted request

// Byte-lane merge cell: chooses the new byte for one lane from the read word
// or from the latched store source.
module store_merge_lane #(
   parameter int LANE = 0,
   parameter int AW   = 2
) (
   input  logic [7:0]    old_byte,
   input  logic [15:0]   src,
   input  logic [1:0]    size,
   input  logic [AW-1:0] addr_lo,
   output logic [7:0]    new_byte
);
   logic hit_lo;
   logic hit_hi;

   // hit_lo: lane takes src[7:0] (byte store, or low half of a halfword).
   // hit_hi: lane is the upper byte of a halfword store.
   assign hit_lo = ((size == 2'b10) || (size == 2'b01)) && (int'(addr_lo) == LANE);
   assign hit_hi = (size == 2'b01) && ((int'(addr_lo) + 1) == LANE);

   always_comb begin
      new_byte = old_byte;
      if (hit_lo)
         new_byte = src[7:0];
      else if (hit_hi)
         new_byte = src[15:8];
   end
endmodule

module store_merge_unit #(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [1:0]                 size,
   input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
   input  logic [DATA_W-1:0]          reg_B_data,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       mem_rd,
   output logic                       mem_wr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic                       busy,
   output logic                       done,
   output logic                       misaligned
);
   localparam int LANES = DATA_W / 8;
   localparam int AW    = $clog2(LANES);
   localparam int CW    = $clog2(RD_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                 state;
   logic [CW-1:0]          wait_cnt;
   logic [1:0]             size_q;
   logic [AW-1:0]          addr_q;
   logic [15:0]            src_q;     // only the low half-word feeds a merge
   logic                   req_err;
   logic [LANES-1:0][7:0]  merged;

   // Reserved size, or a halfword that straddles a half-word boundary.
   assign req_err = (size == 2'b11) || ((size == 2'b01) && addr_lo[0]);

   // Merge is combinational from the live read data; it is registered into
   // mem_wdata on the edge where the read data is valid.
   genvar i;
   generate
      for (i = 0; i < LANES; i++) begin : g_lane
         store_merge_lane #(
            .LANE (i),
            .AW   (AW)
         ) u_lane (
            .old_byte (mem_rdata[8*i +: 8]),
            .src      (src_q),
            .size     (size_q),
            .addr_lo  (addr_q),
            .new_byte (merged[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         size_q     <= '0;
         addr_q     <= '0;
         src_q      <= '0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         // Strobes are single-cycle; each state that needs one sets it for
         // the following cycle.
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  size_q <= size;
                  addr_q <= addr_lo;
                  src_q  <= reg_B_data[15:0];
                  busy   <= 1'b1;
                  if (req_err) begin
                     misaligned <= 1'b1;
                     done       <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     misaligned <= 1'b0;
                     if (size == 2'b00) begin
                        // Full word: no read needed, data goes out directly.
                        mem_wr    <= 1'b1;
                        mem_wdata <= reg_B_data;
                        state     <= S_WRITE;
                     end else begin
                        mem_rd <= 1'b1;
                        state  <= S_READ;
                     end
                  end
               end
            end
            S_READ: begin
               wait_cnt <= CW'(RD_LAT);
               state    <= S_WAIT;
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt - CW'(1);
               if (wait_cnt == CW'(1)) begin
                  // mem_rdata is valid this cycle: capture the merged word.
                  mem_wdata <= merged;
                  mem_wr    <= 1'b1;
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               // A start seen here is deliberately dropped.
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit. Two instances: a 32-bit unit with RD_LAT=1 and
// a 64-bit unit with RD_LAT=3; `sel` picks which one a test drives/observes.
// Each recorded cycle packs {mem_rd, mem_wr, done, busy, misaligned}.
module tb_store_merge_unit;
   localparam int NC    = 16;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        sel = 1'b0;
   logic [1:0]  size = '0;
   logic [2:0]  addr_lo = '0;
   logic [63:0] reg_b = '0;
   logic [63:0] mem_word = '0;

   logic        rd_a, wr_a, busy_a, done_a, mis_a;
   logic [31:0] wdata_a, rdata_a;
   logic        rd_b, wr_b, busy_b, done_b, mis_b;
   logic [63:0] wdata_b, rdata_b;
   logic        start_a, start_b;

   logic        o_rd, o_wr, o_busy, o_done, o_mis;
   logic [63:0] o_wdata;

   int checks = 0;
   int errors = 0;

   logic [NC*5-1:0] trace;
   logic [63:0]     wq [0:3];
   logic [63:0]     drv_b [0:NC];
   int              nwr;

   always #5 clk = ~clk;

   assign start_a = start & ~sel;
   assign start_b = start & sel;

   store_merge_unit #(.DATA_W(32), .RD_LAT(LAT_A)) u_a (
      .clk(clk), .reset(reset), .start(start_a), .size(size),
      .addr_lo(addr_lo[1:0]), .reg_B_data(reg_b[31:0]), .mem_rdata(rdata_a),
      .mem_rd(rd_a), .mem_wr(wr_a), .mem_wdata(wdata_a), .busy(busy_a),
      .done(done_a), .misaligned(mis_a));

   store_merge_unit #(.DATA_W(64), .RD_LAT(LAT_B)) u_b (
      .clk(clk), .reset(reset), .start(start_b), .size(size),
      .addr_lo(addr_lo), .reg_B_data(reg_b), .mem_rdata(rdata_b),
      .mem_rd(rd_b), .mem_wr(wr_b), .mem_wdata(wdata_b), .busy(busy_b),
      .done(done_b), .misaligned(mis_b));

   assign o_rd    = sel ? rd_b   : rd_a;
   assign o_wr    = sel ? wr_b   : wr_a;
   assign o_busy  = sel ? busy_b : busy_a;
   assign o_done  = sel ? done_b : done_a;
   assign o_mis   = sel ? mis_b  : mis_a;
   assign o_wdata = sel ? wdata_b : {32'h0, wdata_a};

   // Memory model: read data is valid only in the single cycle RD_LAT cycles
   // after the mem_rd cycle; random junk is driven at every other time.
   int          cnt_a = 0;
   int          cnt_b = 0;
   logic [63:0] junk = '0;
   always @(posedge clk) begin
      junk  <= {$urandom, $urandom};
      cnt_a <= rd_a ? LAT_A : (cnt_a > 0 ? cnt_a - 1 : 0);
      cnt_b <= rd_b ? LAT_B : (cnt_b > 0 ? cnt_b - 1 : 0);
   end
   assign rdata_a = (cnt_a == 1) ? mem_word[31:0] : junk[31:0];
   assign rdata_b = (cnt_b == 1) ? mem_word : junk;

   // Reference: expected strobe trace derived from the latency rules.
   function automatic logic [NC*5-1:0] model_trace(input logic [1:0] sz, input logic [2:0] ad,
                                                   input int lat, input bit hold);
      logic [NC*5-1:0] tr;
      bit err;
      int rd_c, wr_c, dn_c, r;
      tr  = '0;
      err = (sz == 2'b11) || (sz == 2'b01 && ad[0]);
      if (err) begin rd_c = 0; wr_c = 0; dn_c = 1; end
      else if (sz == 2'b00) begin rd_c = 0; wr_c = 1; dn_c = 2; end
      else begin rd_c = 1; wr_c = lat + 2; dn_c = lat + 3; end
      for (int c = 1; c <= NC; c++) begin
         // With start held, a new request starts every dn_c+1 cycles.
         r = hold ? ((c - 1) % (dn_c + 1)) + 1 : c;
         tr[(c-1)*5 +: 5] = {r == rd_c, r == wr_c, r == dn_c, r <= dn_c, err};
      end
      return tr;
   endfunction

   // Reference: expected write word via masks and shifts.
   function automatic logic [63:0] model_wdata(input logic [1:0] sz, input logic [2:0] ad,
                                               input logic [63:0] b, input logic [63:0] old,
                                               input bit w64);
      logic [63:0] lo, m, res;
      lo = (sz == 2'b10) ? 64'hFF : 64'hFFFF;
      if (sz == 2'b00) res = b;
      else begin
         m   = lo << (8 * ad);
         res = (old & ~m) | ((b & lo) << (8 * ad));
      end
      if (!w64) res[63:32] = '0;
      return res;
   endfunction

   // Drives one request from a negedge, records NC cycles, then drains.
   task automatic exec_store(input logic [1:0] sz, input logic [2:0] ad,
                             input logic [63:0] b, input bit hold);
      size = sz; addr_lo = ad; reg_b = b; drv_b[0] = b; start = 1'b1;
      nwr = 0;
      @(posedge clk);
      for (int c = 1; c <= NC; c++) begin
         @(negedge clk);
         trace[(c-1)*5 +: 5] = {o_rd, o_wr, o_done, o_busy, o_mis};
         if (o_wr) begin
            if (nwr < 4) wq[nwr] = o_wdata;
            nwr++;
         end
         reg_b = {$urandom, $urandom};
         drv_b[c] = reg_b;
         if (!hold) begin
            start = 1'b0;
            size = 2'($urandom);
            addr_lo = 3'($urandom);
         end
      end
      start = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      #12;
      sel = 1'b0; #1;
      checks++;
      if ({o_rd, o_wr, o_done, o_busy, o_mis, o_wdata} !== 69'h0) begin
         errors++; $display("FAIL reset_a: got %h want 0", {o_rd, o_wr, o_done, o_busy, o_mis, o_wdata});
      end
      sel = 1'b1; #1;
      checks++;
      if ({o_rd, o_wr, o_done, o_busy, o_mis, o_wdata} !== 69'h0) begin
         errors++; $display("FAIL reset_b: got %h want 0", {o_rd, o_wr, o_done, o_busy, o_mis, o_wdata});
      end
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_word_store();
      logic [NC*5-1:0] exp;
      sel = 1'b0;
      exec_store(2'b00, 3'd0, 64'hDEADBEEF, 1'b0);
      exp = model_trace(2'b00, 3'd0, LAT_A, 1'b0);
      checks++;
      if (trace !== exp) begin errors++; $display("FAIL word_trace: got %h want %h", trace, exp); end
      checks++;
      if (nwr !== 1 || wq[0] !== 64'hDEADBEEF) begin
         errors++; $display("FAIL word_wdata: got %h (writes %0d) want deadbeef", wq[0], nwr);
      end
      checks++;
      if (o_wdata !== 64'hDEADBEEF) begin errors++; $display("FAIL word_hold: got %h want deadbeef", o_wdata); end
   endtask

   task automatic test_byte_store();
      logic [NC*5-1:0] exp;
      sel = 1'b0;
      mem_word = 64'h0000_0000_1122_3344;
      exec_store(2'b10, 3'd2, 64'h0000_00AB, 1'b0);
      exp = model_trace(2'b10, 3'd2, LAT_A, 1'b0);
      checks++;
      if (trace !== exp) begin errors++; $display("FAIL byte_trace: got %h want %h", trace, exp); end
      checks++;
      if (nwr !== 1 || wq[0] !== 64'h11AB3344) begin
         errors++; $display("FAIL byte_wdata: got %h (writes %0d) want 11ab3344", wq[0], nwr);
      end
   endtask

   task automatic test_half_store();
      logic [NC*5-1:0] exp;
      sel = 1'b1;
      mem_word = 64'h5566_7788_1122_3344;
      exec_store(2'b01, 3'd2, 64'h0000_CAFE, 1'b0);
      exp = model_trace(2'b01, 3'd2, LAT_B, 1'b0);
      checks++;
      if (trace !== exp) begin errors++; $display("FAIL half_trace: got %h want %h", trace, exp); end
      checks++;
      if (nwr !== 1 || wq[0] !== 64'h5566_7788_CAFE_3344) begin
         errors++; $display("FAIL half_wdata: got %h (writes %0d) want 55667788cafe3344", wq[0], nwr);
      end
   endtask

   task automatic test_misaligned();
      logic [NC*5-1:0] exp;
      sel = 1'b0;
      exec_store(2'b01, 3'd1, 64'h1234, 1'b0);
      exp = model_trace(2'b01, 3'd1, LAT_A, 1'b0);
      checks++;
      if (trace !== exp || nwr !== 0) begin errors++; $display("FAIL mis_half: got %h want %h", trace, exp); end
      exec_store(2'b11, 3'd0, 64'h5678, 1'b0);
      exp = model_trace(2'b11, 3'd0, LAT_A, 1'b0);
      checks++;
      if (trace !== exp || nwr !== 0) begin errors++; $display("FAIL mis_rsvd: got %h want %h", trace, exp); end
      exec_store(2'b00, 3'd0, 64'h0BADF00D, 1'b0);
      exp = model_trace(2'b00, 3'd0, LAT_A, 1'b0);
      checks++;
      if (trace !== exp) begin errors++; $display("FAIL mis_clear: got %h want %h", trace, exp); end
   endtask

   task automatic test_hold_start();
      logic [NC*5-1:0] exp;
      logic [63:0] e0, e1;
      sel = 1'b1;
      mem_word = {$urandom, $urandom};
      exec_store(2'b10, 3'd7, {$urandom, $urandom}, 1'b1);
      exp = model_trace(2'b10, 3'd7, LAT_B, 1'b1);
      checks++;
      if (trace !== exp) begin errors++; $display("FAIL hold_trace: got %h want %h", trace, exp); end
      e0 = model_wdata(2'b10, 3'd7, drv_b[0], mem_word, 1'b1);
      e1 = model_wdata(2'b10, 3'd7, drv_b[LAT_B + 4], mem_word, 1'b1);
      checks++;
      if (nwr !== 2 || wq[0] !== e0 || wq[1] !== e1) begin
         errors++; $display("FAIL hold_wdata: got %h %h (writes %0d) want %h %h", wq[0], wq[1], nwr, e0, e1);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [NC*5-1:0] exp;
      bit seen;
      sel = 1'b1;
      mem_word = {$urandom, $urandom};
      size = 2'b10; addr_lo = 3'd1; reg_b = {$urandom, $urandom}; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      checks++;
      if ({o_rd, o_wr, o_busy} !== 3'b001) begin
         errors++; $display("FAIL rst_pre: got %b want 001", {o_rd, o_wr, o_busy});
      end
      reset = 1'b1; #1;
      checks++;
      if ({o_rd, o_wr, o_done, o_busy, o_mis, o_wdata} !== 69'h0) begin
         errors++; $display("FAIL rst_async: got %h want 0", {o_rd, o_wr, o_done, o_busy, o_mis, o_wdata});
      end
      seen = 1'b0;
      repeat (3) begin @(negedge clk); seen |= o_wr | o_busy; end
      reset = 1'b0;
      repeat (6) begin @(negedge clk); seen |= o_wr | o_busy; end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL rst_nowr: got %b want 0", seen); end
      exec_store(2'b00, 3'd0, 64'hFEED_FACE_0123_4567, 1'b0);
      exp = model_trace(2'b00, 3'd0, LAT_B, 1'b0);
      checks++;
      if (trace !== exp || nwr !== 1 || wq[0] !== 64'hFEED_FACE_0123_4567) begin
         errors++; $display("FAIL rst_after: got %h %h want %h feedface01234567", trace, wq[0], exp);
      end
   endtask

   task automatic test_random();
      logic [NC*5-1:0] exp;
      logic [63:0] b, ew;
      logic [1:0] sz;
      logic [2:0] ad;
      bit err;
      for (int n = 0; n < 24; n++) begin
         sel = 1'($urandom);
         sz = 2'($urandom);
         ad = sel ? 3'($urandom_range(7, 0)) : 3'($urandom_range(3, 0));
         b = {$urandom, $urandom};
         mem_word = {$urandom, $urandom};
         err = (sz == 2'b11) || (sz == 2'b01 && ad[0]);
         exec_store(sz, ad, b, 1'b0);
         exp = model_trace(sz, ad, sel ? LAT_B : LAT_A, 1'b0);
         ew = model_wdata(sz, ad, b, sel ? mem_word : {32'h0, mem_word[31:0]}, sel);
         checks++;
         if (trace !== exp) begin
            errors++; $display("FAIL rnd%0d_trace: got %h want %h", n, trace, exp);
         end
         checks++;
         if (nwr !== (err ? 0 : 1) || (!err && wq[0] !== ew)) begin
            errors++; $display("FAIL rnd%0d_wdata: got %h (writes %0d) want %h", n, wq[0], nwr, ew);
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_byte_store();
      test_half_store();
      test_misaligned();
      test_hold_start();
      test_reset_mid_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
